fib_seq_engine: RTL and testbench
=================================

// Module: fib_seq_engine
// PURPOSE
//  Parametrised successor of the team's fixed Fibonacci FSM: computes a(L) of a
//  generalised additive sequence a(0)=S0, a(1)=S1, a(n)=a(n-1)+a(n-2).
//  Valid/ready on both sides, configurable data/level width, overflow reporting.
//  Single-job engine used as a sequence/test-pattern generator in the datapath.
// PARAMETERS
//  DATA_W   16  width of seeds, internal terms and result
//  LEVEL_W   8  width of requested index L
// PORTS
//  clk        in   1        rising-edge clock, sole clock domain
//  rst_n      in   1        reset, synchronous, active-low
//  in_valid   in   1        request valid
//  in_ready   out  1        engine can accept request (combinational)
//  in_level   in   LEVEL_W  index L to compute
//  in_seed0   in   DATA_W   a(0)
//  in_seed1   in   DATA_W   a(1)
//  out_valid  out  1        result valid, held until out_ready
//  out_ready  in   1        consumer accepts result
//  result     out  DATA_W   a(L) (see overflow rules)
//  overflow   out  1        sticky: some term of this job exceeded DATA_W
// BEHAVIOUR
//  - Reset (rst_n low at clk edge, any state): state=IDLE, out_valid=0,
//    result=0, overflow=0, internal x/y/cnt=0; in-flight job discarded.
//  - Accept = in_valid & in_ready; in_ready = (IDLE) | (DONE & out_ready).
//  - On accept: x<=S0, y<=S1, cnt<=L, overflow<=0, out_valid<=0.
//      L==0 -> DONE, result<=S0.  L==1 -> DONE, result<=S1.  L>=2 -> CALC.
//  - CALC, per cycle: sum={1'b0,x}+{1'b0,y} (DATA_W+1 bits); x<=y;
//    y<=sum[DATA_W-1:0]; overflow|=sum[DATA_W]; cnt<=cnt-1.
//    When cnt==2 (last step): -> DONE, result<=final y, out_valid<=1.
//  - Latency: L>=2 -> out_valid rises L-1 edges after accept edge;
//    L<=1 -> out_valid rises on the accept edge (1 cycle later visible).
//  - CALC ignores in_valid (in_ready=0) and out_ready.
//  - DONE: out_valid=1, result/overflow stable until out_ready high at edge.
//    out_ready & !in_valid -> IDLE, out_valid<=0.
//    out_ready & in_valid  -> back-to-back: new job accepted same edge.
//  - IDLE: out_valid=0, result/overflow hold last values.
//  - Unreachable state encodings -> IDLE next cycle.
//  - L = 2^LEVEL_W-1 legal; no wrap of cnt (counts down to 2 only).
// CONFIGURATION
//  FIB_SAT_EN defined: once overflow set in a job, y forced to all-ones and
//    held; result reports {DATA_W{1'b1}}; overflow=1.
//  FIB_SAT_EN undefined: arithmetic wraps modulo 2^DATA_W; result is wrapped
//    value; overflow still flagged.
// TESTING
//  T1 S0=0,S1=1,L=10 -> out_valid after 9 cycles, result=55, overflow=0.
//  T2 S0=2,S1=1,L=5 (Lucas) -> result=11; L=0 -> 2; L=1 -> 1, 1-cycle latency.
//  T3 DATA_W=16,S0=0,S1=1,L=25 -> overflow=1; result=9489 (wrap) or 65535 (FIB_SAT_EN).
//  T4 out_ready low 5 cycles in DONE -> result/out_valid stable; in_valid ignored.
//  T5 out_ready & in_valid same edge in DONE -> next job accepted, no IDLE cycle.
//  T6 rst_n low mid-CALC (L=20) -> next cycle IDLE, outputs 0; new job L=10 -> 55.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Generalised additive-sequence engine: a(0)=S0, a(1)=S1, a(n)=a(n-1)+a(n-2), returns a(L).
// Optional macro FIB_SAT_EN: saturate to all-ones after overflow instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for a request, result/overflow hold last job
// CALC    | stepping the recurrence, one term per cycle
// DONE    | result valid, held until out_ready
module fib_seq_engine #(
  parameter int DATA_W  = 16,
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEVEL_W-1:0] in_level,
  input  logic [DATA_W-1:0]  in_seed0,
  input  logic [DATA_W-1:0]  in_seed1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'(2);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   x, x_nxt;
  logic [DATA_W-1:0]   y, y_nxt;
  logic [LEVEL_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0]   result_nxt;
  logic                overflow_nxt;
  logic                out_valid_nxt;
  logic                accept;
  logic [DATA_W:0]     sum;
  logic                ovf_step;
  logic [DATA_W-1:0]   y_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      cnt       <= cnt_nxt;
      result    <= result_nxt;
      overflow  <= overflow_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    x_nxt         = x;
    y_nxt         = y;
    cnt_nxt       = cnt;
    result_nxt    = result;
    overflow_nxt  = overflow;
    out_valid_nxt = out_valid;

    in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    accept   = in_valid & in_ready;

    sum      = {1'b0, x} + {1'b0, y};
    ovf_step = overflow | sum[DATA_W];
`ifdef FIB_SAT_EN
    // once a job has overflowed, the running term is pinned at all-ones
    y_step   = ovf_step ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    y_step   = sum[DATA_W-1:0];
`endif

    case (state)
      ST_IDLE: out_valid_nxt = 1'b0;
      ST_CALC: begin
        x_nxt        = y;
        y_nxt        = y_step;
        overflow_nxt = ovf_step;
        cnt_nxt      = cnt - LVL_ONE;
        if (cnt == CNT_LAST) begin
          state_nxt     = ST_DONE;
          result_nxt    = y_step;
          out_valid_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid_nxt = 1'b1;
        if (out_ready) begin
          state_nxt     = ST_IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        out_valid_nxt = 1'b0;
      end
    endcase

    // a new job may start from IDLE or back-to-back out of DONE
    if (accept) begin
      x_nxt         = in_seed0;
      y_nxt         = in_seed1;
      cnt_nxt       = in_level;
      overflow_nxt  = 1'b0;
      out_valid_nxt = 1'b0;
      state_nxt     = ST_CALC;
      if (in_level == '0) begin
        state_nxt     = ST_DONE;
        result_nxt    = in_seed0;
        out_valid_nxt = 1'b1;
      end else if (in_level == LVL_ONE) begin
        state_nxt     = ST_DONE;
        result_nxt    = in_seed1;
        out_valid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine (DATA_W=16, LEVEL_W=8); honours FIB_SAT_EN for expectations.
module tb_fib_seq_engine;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_level;
  logic [DW-1:0] in_seed0;
  logic [DW-1:0] in_seed1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          overflow;

  int n_chk = 0;
  int n_bad = 0;

  fib_seq_engine #(.DATA_W(DW), .LEVEL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
    .in_seed0(in_seed0), .in_seed1(in_seed1),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference for the long-run case; saturation mirrors the documented FIB_SAT_EN behaviour
  function automatic void fib_ref(input int s0, input int s1, input int l,
                                  output int res, output bit ovf);
    int a, b, s, nb;
    a = s0; b = s1; ovf = 0;
    if (l == 0) res = a;
    else begin
      for (int i = 2; i <= l; i++) begin
        s = a + b;
        if (s > 65535) ovf = 1;
`ifdef FIB_SAT_EN
        nb = ovf ? 65535 : s;
`else
        nb = s & 65535;
`endif
        a = b; b = nb;
      end
      res = b;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present a request and return just after the accepting edge
  task automatic issue(input int s0, input int s1, input int l);
    int n;
    n = 0;
    in_seed0  = DW'(s0);
    in_seed1  = DW'(s1);
    in_level  = LW'(l);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int  lat;
    bit  seen;
    lat = 0; seen = 0;
    while (!out_valid && lat < 400) begin
      if (!seen) begin
        chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        seen = 1;
      end
      step(); lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_job(input string tag, input int s0, input int s1, input int l,
                         input int exp_res, input bit exp_ovf);
    issue(s0, s1, l);
    wait_out(tag, (l < 2) ? 0 : l - 1);
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  int t3_exp;
  int rref;
  bit oref;

  initial begin
`ifdef FIB_SAT_EN
    t3_exp = 65535;
`else
    t3_exp = 9489;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_level = '0; in_seed0 = '0; in_seed1 = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    run_job("t1", 0, 1, 10, 55, 0);
    consume("t1");

    run_job("t2_l5", 2, 1, 5, 11, 0);
    consume("t2_l5");
    run_job("t2_l0", 2, 1, 0, 2, 0);
    consume("t2_l0");
    run_job("t2_l1", 2, 1, 1, 1, 0);
    consume("t2_l1");

    run_job("t3", 0, 1, 25, t3_exp, 1);
    consume("t3");
    step(); step();
    chk("t3_hold_res", 32'(result), 32'(t3_exp));
    chk("t3_hold_ovf", 32'(overflow), 32'd1);
    chk("t3_hold_valid", 32'(out_valid), 32'd0);

    run_job("clr", 3, 4, 4, 18, 0);

    // T4: stall in DONE with a competing request that must be ignored
    in_valid = 1'b1; in_level = '0; in_seed0 = 16'd99; in_seed1 = 16'd98;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_res", 32'(result), 32'd18);
    end

    // T5: back-to-back accept out of DONE
    in_seed0 = 16'd0; in_seed1 = 16'd1; in_level = 8'd3;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_valid_drop", 32'(out_valid), 32'd0);
    wait_out("t5", 2);
    chk("t5_res", 32'(result), 32'd2);
    in_valid = 1'b1; in_seed0 = 16'd7; in_level = 8'd0; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5b_valid", 32'(out_valid), 32'd1);
    chk("t5b_res", 32'(result), 32'd7);
    consume("t5b");

    // T6: reset in the middle of a long job
    issue(0, 1, 20);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_res", 32'(result), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();
    run_job("t6_after", 0, 1, 10, 55, 0);
    consume("t6_after");

    fib_ref(0, 1, 255, rref, oref);
    run_job("lmax", 0, 1, 255, rref, oref);
    consume("lmax");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
